// File: rtl/struct_lane_assembler_pkg.sv
// Shared types for the lane assembler: lane ordering, assembler states and
// the width helper for the lane count output.
package struct_lane_pkg;

    typedef enum logic {
        LANE_DESC = 1'b0,
        LANE_ASC  = 1'b1
    } lane_order_e;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } asm_state_e;

    function automatic int count_w(input int num_lanes);
        return $clog2(num_lanes + 1);
    endfunction

endpackage

// File: rtl/struct_lane_assembler_outreg.sv
// One-deep valid/ready output register holding a finished record and its
// lane count; accepts a new record whenever it is empty or being drained.
module struct_lane_outreg #(
    parameter int REC_W = 80,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [REC_W-1:0] ld_rec,
    input  logic [CNT_W-1:0] ld_cnt,
    input  logic             out_ready,
    output logic             free,
    output logic             out_valid,
    output logic [REC_W-1:0] out_rec,
    output logic [CNT_W-1:0] out_count
);

    logic             valid_q, valid_d;
    logic [REC_W-1:0] rec_q, rec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        free    = !valid_q || out_ready;
        valid_d = valid_q;
        rec_d   = rec_q;
        cnt_d   = cnt_q;
        if (load) begin
            valid_d = 1'b1;
            rec_d   = ld_rec;
            cnt_d   = ld_cnt;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            rec_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rec_q   <= rec_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_rec   = rec_q;
    assign out_count = cnt_q;

endmodule

// File: rtl/struct_lane_assembler.sv
// Gathers IN_LANES-wide beats into a packed {a[NUM_LANES], b} record with
// selectable lane order, early close on in_last and a one-deep hold stage.
module struct_lane_assembler
    import struct_lane_pkg::*;
#(
    parameter int LANE_W    = 8,
    parameter int NUM_LANES = 8,
    parameter int IN_LANES  = 2,
    parameter int TAG_W     = 16,
    parameter int ASCENDING = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [IN_LANES*LANE_W-1:0]    in_data,
    input  logic [TAG_W-1:0]              in_tag,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_LANES*LANE_W+TAG_W-1:0] out_rec,
    output logic [$clog2(NUM_LANES+1)-1:0]    out_count
);

    localparam int BEATS = NUM_LANES / IN_LANES;
    localparam int PTR_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CNT_W = count_w(NUM_LANES);
    localparam int REC_W = NUM_LANES * LANE_W + TAG_W;
    localparam lane_order_e ORDER = (ASCENDING != 0) ? LANE_ASC : LANE_DESC;

    typedef struct packed {
        logic [NUM_LANES-1:0][LANE_W-1:0] a;
        logic [TAG_W-1:0]                 b;
    } rec_t;

    // Ascending declaration puts logical lane 0 in the most significant slot.
    function automatic logic [IDX_W-1:0] phys_idx(input logic [IDX_W-1:0] i);
        return (ORDER == LANE_ASC) ? IDX_W'(NUM_LANES - 1) - i : i;
    endfunction

    asm_state_e       state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    rec_t             asm_q, asm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    rec_t             beat_rec;
    logic [CNT_W-1:0] beat_cnt;
    logic [IDX_W-1:0] lane_idx;
    logic             done;
    logic             load;
    rec_t             ld_rec;
    logic [CNT_W-1:0] ld_cnt;
    logic             free;

    always_comb begin
        lane_idx = '0;
        beat_rec = asm_q;
        if (ptr_q == '0) begin
            beat_rec   = '0;
            beat_rec.b = in_tag;
        end
        for (int j = 0; j < IN_LANES; j++) begin
            lane_idx = IDX_W'(int'(ptr_q) * IN_LANES + j);
            beat_rec.a[phys_idx(lane_idx)] = in_data[j*LANE_W +: LANE_W];
        end
        beat_cnt = CNT_W'((int'(ptr_q) + 1) * IN_LANES);
        done     = in_last || (ptr_q == PTR_W'(BEATS - 1));
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        asm_d    = asm_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        ld_rec   = asm_q;
        ld_cnt   = cnt_q;
        in_ready = (state_q == ST_FILL);
        case (state_q)
            ST_FILL: begin
                if (in_valid) begin
                    if (done) begin
                        ptr_d = '0;
                        // A free output register takes the record directly, skipping HOLD.
                        if (free) begin
                            load   = 1'b1;
                            ld_rec = beat_rec;
                            ld_cnt = beat_cnt;
                        end else begin
                            asm_d   = beat_rec;
                            cnt_d   = beat_cnt;
                            state_d = ST_HOLD;
                        end
                    end else begin
                        asm_d = beat_rec;
                        ptr_d = ptr_q + PTR_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (free) begin
                    load    = 1'b1;
                    ptr_d   = '0;
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FILL;
            ptr_q   <= '0;
            asm_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            asm_q   <= asm_d;
            cnt_q   <= cnt_d;
        end
    end

    struct_lane_outreg #(
        .REC_W(REC_W),
        .CNT_W(CNT_W)
    ) u_outreg (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .ld_rec   (ld_rec),
        .ld_cnt   (ld_cnt),
        .out_ready(out_ready),
        .free     (free),
        .out_valid(out_valid),
        .out_rec  (out_rec),
        .out_count(out_count)
    );

endmodule

// File: tb/tb_struct_lane_assembler.sv
// Bench for struct_lane_assembler: descending and ascending instances share
// stimulus; table vectors, corner sequences and a randomized scoreboard run.
module tb_struct_lane_assembler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_data = '0;
    logic [15:0] in_tag = '0;
    logic        in_ready0, in_ready1, out_valid0, out_valid1;
    logic [79:0] out_rec0, out_rec1;
    logic [3:0]  out_count0, out_count1;

    always #5 clk = ~clk;

    struct_lane_assembler #(.LANE_W(8), .NUM_LANES(8), .IN_LANES(2), .TAG_W(16), .ASCENDING(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .in_tag(in_tag), .in_last(in_last), .out_valid(out_valid0), .out_ready(out_ready),
        .out_rec(out_rec0), .out_count(out_count0));

    struct_lane_assembler #(.LANE_W(8), .NUM_LANES(8), .IN_LANES(2), .TAG_W(16), .ASCENDING(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .in_tag(in_tag), .in_last(in_last), .out_valid(out_valid1), .out_ready(out_ready),
        .out_rec(out_rec1), .out_count(out_count1));

    int n_checks = 0;
    int n_pass = 0;
    int stalls = 0;
    int hs_count = 0;
    bit rand_ready = 0;

    typedef struct {
        logic [79:0] r0;
        logic [79:0] r1;
        logic [3:0]  cnt;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [15:0] tag;
        logic [63:0] beats;
        int          n;
        bit          lf;
        logic [79:0] e0;
        logic [79:0] e1;
        logic [3:0]  cnt;
    } vec_t;
    vec_t vt[4];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: logical lane i lands in slot i (descending) or slot 7-i (ascending).
    function automatic logic [79:0] model(input logic [15:0] tag, input logic [63:0] lanes, input bit asc);
        logic [79:0] r = '0;
        r[15:0] = tag;
        for (int i = 0; i < 8; i++) begin
            int pos = asc ? 7 - i : i;
            r[16 + pos*8 +: 8] = lanes[i*8 +: 8];
        end
        return r;
    endfunction

    task automatic send_beat(input logic [15:0] d, input logic [15:0] tag, input logic last);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_tag   = tag;
        in_last  = last;
        while (!in_ready0 && waited < 200) begin
            @(posedge clk); #1;
            waited++;
            stalls++;
        end
        if (!in_ready0) begin
            n_checks++;
            $display("FAIL in_ready_timeout: in_ready stayed %0b for %0d cycles, required 1", in_ready0, waited);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_record(input logic [15:0] tag, input logic [63:0] beats, input int n,
                               input bit last_full, input bit gaps);
        logic [63:0] lanes = '0;
        exp_t e;
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                int g = $urandom_range(0, 2);
                in_valid = 1'b0;
                in_data  = 16'($urandom);
                in_tag   = 16'($urandom);
                in_last  = 1'($urandom);
                repeat (g) begin @(posedge clk); #1; end
            end
            lanes[k*16 +: 16] = beats[k*16 +: 16];
            send_beat(beats[k*16 +: 16], (k == 0) ? tag : 16'($urandom),
                      1'((k == n - 1) && (n < 4 || last_full)));
        end
        e.r0  = model(tag, lanes, 1'b0);
        e.r1  = model(tag, lanes, 1'b1);
        e.cnt = 4'(n * 2);
        exp_q.push_back(e);
    endtask

    // Scoreboard: delivered records in order, held records stable under backpressure.
    logic [79:0] h0, h1;
    logic [3:0]  hc;
    bit          held = 0;
    always @(negedge clk) begin
        if (rst) begin
            held = 0;
        end else begin
            if (held && out_valid0) begin
                chk("hold_rec0", out_rec0, h0);
                chk("hold_rec1", out_rec1, h1);
                chk("hold_cnt", out_count0, hc);
            end
            if (out_valid0 && out_ready) begin
                hs_count++;
                n_checks++;
                if (exp_q.size() != 0) begin
                    exp_t e;
                    n_pass++;
                    e = exp_q.pop_front();
                    chk("sb_rec0", out_rec0, e.r0);
                    chk("sb_rec1", out_rec1, e.r1);
                    chk("sb_cnt0", out_count0, e.cnt);
                    chk("sb_cnt1", out_count1, e.cnt);
                end else begin
                    $display("FAIL sb_unexpected: got record %h, required none", out_rec0);
                end
            end
            held = out_valid0 && !out_ready;
            h0 = out_rec0;
            h1 = out_rec1;
            hc = out_count0;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_base;
        int w;
        vt[0] = '{16'hFFFC, 64'hFC00_4200_0012_3400, 4, 1'b0,
                  80'hFC00_4200_0012_3400_FFFC, 80'h0034_1200_0042_00FC_FFFC, 4'd8};
        vt[1] = '{16'hFFFC, 64'h0000_0000_0000_3400, 1, 1'b1,
                  80'h0000_0000_0000_3400_FFFC, 80'h0034_0000_0000_0000_FFFC, 4'd2};
        vt[2] = '{16'h1234, 64'h0000_0605_0403_0201, 3, 1'b1,
                  80'h0000_0605_0403_0201_1234, 80'h0102_0304_0506_0000_1234, 4'd6};
        vt[3] = '{16'hABCD, 64'h4444_3333_2222_1111, 4, 1'b1,
                  80'h4444_3333_2222_1111_ABCD, 80'h1111_2222_3333_4444_ABCD, 4'd8};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_out_rec", out_rec0, 0);
        chk("rst_out_count", out_count0, 0);
        chk("rst_in_ready", in_ready0, 1);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            send_record(vt[i].tag, vt[i].beats, vt[i].n, vt[i].lf, 1'b0);
            in_valid = 1'b0;
            chk("vec_out_valid", out_valid0, 1);
            chk("vec_out_valid_asc", out_valid1, 1);
            chk("vec_rec_desc", out_rec0, vt[i].e0);
            chk("vec_rec_asc", out_rec1, vt[i].e1);
            chk("vec_count", out_count0, vt[i].cnt);
            chk("vec_count_asc", out_count1, vt[i].cnt);
            @(posedge clk); #1;
        end

        out_ready = 1'b0;
        send_record(16'h1111, {$urandom, $urandom}, 4, 1'b0, 1'b0);
        send_record(16'h2222, {$urandom, $urandom}, 4, 1'b0, 1'b0);
        in_valid = 1'b0;
        chk("bp_in_ready", in_ready0, 0);
        chk("bp_in_ready_asc", in_ready1, 0);
        chk("bp_out_valid", out_valid0, 1);
        repeat (3) begin @(posedge clk); #1; end
        chk("bp_in_ready_held", in_ready0, 0);
        out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("bp_in_ready_back", in_ready0, 1);
        chk("bp_drained", exp_q.size(), 0);
        chk("bp_out_valid_low", out_valid0, 0);

        out_ready = 1'b0;
        send_record(16'h7777, {$urandom, $urandom}, 4, 1'b0, 1'b0);
        send_beat(16'hAAAA, 16'hBEEF, 1'b0);
        send_beat(16'hBBBB, 16'h0000, 1'b0);
        in_valid = 1'b0;
        chk("pre_rst_out_valid", out_valid0, 1);
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("mid_rst_out_valid", out_valid0, 0);
        chk("mid_rst_out_rec", out_rec0, 0);
        chk("mid_rst_out_count", out_count0, 0);
        chk("mid_rst_in_ready", in_ready0, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send_record(16'h5A5A, 64'h0807_0605_0403_0201, 4, 1'b0, 1'b0);
        in_valid = 1'b0;
        chk("post_rst_rec", out_rec0, 80'h0807_0605_0403_0201_5A5A);
        chk("post_rst_count", out_count0, 8);
        repeat (2) begin @(posedge clk); #1; end

        stalls = 0;
        hs_base = hs_count;
        for (int r = 0; r < 3; r++)
            send_record(16'($urandom), {$urandom, $urandom}, 4, 1'b0, 1'b0);
        in_valid = 1'b0;
        chk("tp_stalls", stalls, 0);
        repeat (2) begin @(posedge clk); #1; end
        chk("tp_records", hs_count - hs_base, 3);

        rand_ready = 1;
        for (int r = 0; r < 60; r++)
            send_record(16'($urandom), {$urandom, $urandom}, $urandom_range(1, 4),
                        1'($urandom_range(0, 1)), 1'b1);
        in_valid = 1'b0;
        rand_ready = 0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        chk("rand_drained", exp_q.size(), 0);
        @(posedge clk); #1;
        chk("final_in_ready", in_ready0, 1);
        chk("final_out_valid", out_valid0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
